l2_assoc: RTL
=============

# l2_assoc

Parametrised N-way set-associative L2 cache with true-LRU replacement, write-back dirty tracking and a valid/ready request handshake. It generalises the fixed 4-set L2 block:
- way count and index width are parameters;
- write hits update in place instead of allocating duplicates;
- full sets evict by LRU, and dirty victims are reported to the next memory level.

It sits between the L1 miss path and the memory-side write-back port.

## Interface
- WORD_SIZE, 32, address and data width
- INDEX_SIZE, 4, set-index bits; SETS = 2**INDEX_SIZE
- OFFSET_SIZE, 2, low address bits ignored (byte offset)
- WAYS, 4, associativity; power of two, >= 2
- TAG_SIZE (localparam), WORD_SIZE-INDEX_SIZE-OFFSET_SIZE
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE and rst_n=1
- wr_en  in  1  1 = write, 0 = read; sampled on accept
- addr  in  WORD_SIZE  tag = addr[WORD_SIZE-1 -: TAG_SIZE], index = next INDEX_SIZE bits
- wdata  in  WORD_SIZE  write data, sampled on accept
- resp_valid  out  1  one-cycle response pulse
- rdata  out  WORD_SIZE  read-hit data / echoed write data / 0 on read miss
- hit  out  1  lookup hit, valid with resp_valid
- evict_valid  out  1  dirty victim written back, valid with resp_valid
- evict_addr  out  WORD_SIZE  {victim tag, index, OFFSET_SIZE'b0}
- evict_data  out  WORD_SIZE  victim data

## Operation
- Line state per way: valid, dirty, tag, data. Each set has WAYS age counters, log2(WAYS) bits each.
- Accept: req_valid && req_ready at a rising edge. The block latches wr_en, tag, index and wdata, then goes IDLE -> LOOKUP. req_valid outside IDLE is ignored; no queuing.
- LOOKUP resolves one of four cases, then RESP:
  - Read hit: rdata = line data, hit = 1, LRU touch.
  - Read miss: hit = 0, rdata = 0. No allocation, no LRU change.
  - Write hit: overwrite data, set dirty, hit = 1, rdata = wdata, LRU touch.
  - Write miss: pick the lowest-numbered invalid way. If there is none, pick the way whose age = WAYS-1. If that victim is valid and dirty, evict_valid = 1 with its addr/data. Install {valid = 1, dirty = 1, tag, wdata}. hit = 0, rdata = wdata, LRU touch.
- LRU touch of way w, with old age a: age[w] <= 0; every way with age < a increments. Ages remain a permutation of 0..WAYS-1.
- RESP: resp_valid = 1 for exactly one cycle, then -> IDLE. There is no response backpressure.
- Outputs rdata, hit and evict_* hold their values until the next RESP. evict_valid is cleared in every cycle other than a RESP with a dirty eviction.

## Timing
- Accept at edge T. LOOKUP occupies cycle T..T+1. resp_valid is high in cycle T+2. req_ready is high again in cycle T+3.
- Maximum throughput is one request per 3 cycles.
- Array updates (data, dirty, ages) commit at the LOOKUP->RESP edge. A read in the next request sees the write.
- Reset (rst_n low at an edge), abandoning any in-flight request without a response:
  - state = IDLE; all valid and dirty bits = 0;
  - age[way i] = i in every set;
  - resp_valid, hit, evict_valid = 0; rdata, evict_addr, evict_data = 0;
  - req_ready = 0 while rst_n is low.

## Structure
- Package l2_pkg holds:
  - state enum {IDLE, LOOKUP, RESP};
  - line struct {valid, dirty, tag, data}, parametrised through the module's typedef of TAG_SIZE/WORD_SIZE widths;
  - a clog2 helper for age width.
- Sub-module l2_lru is combinational. It takes the ages of one set plus the touched way and produces next ages and the victim way. It is instantiated once for the indexed set.
- The main module holds the FSM, the tag compare, the line array and the age array.

## Test plan
Defaults: index 0, tag k at addr = k*0x40.
- Reset, then read 0x40: resp_valid 2 cycles after accept, hit = 0, rdata = 0, evict_valid = 0.
- Write 0x40 with 0xDEADBEEF: hit = 0, evict_valid = 0. Then read 0x40: hit = 1, rdata = 0xDEADBEEF.
- Write 0x40 with 0x12345678 (write hit): hit = 1. Read 0x40 returns 0x12345678, and no second way is allocated (verify by the next test's eviction order).
- LRU eviction sequence:
  - Write 0x40, 0x80, 0xC0, 0x100 with data 1..4.
  - Read 0x40, then write 0x140 with data 5: evict_valid = 1, evict_addr = 0x80, evict_data = 2.
  - Then read 0x80: miss. Read 0x40: hit, rdata = 1.
- Handshake: hold req_valid high with 3 reads. Each is accepted exactly every 3 cycles, req_ready is low in LOOKUP/RESP, and exactly 3 resp_valid pulses occur.
- Reset mid-write: rst_n low for one cycle during LOOKUP of a write to 0x40. No resp_valid follows. A subsequent read of 0x40 gives hit = 0, rdata = 0.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types for the set-associative L2: FSM states and an age-width helper.
package l2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } state_t;

    // Ceiling log2 for constant parameter evaluation; returns at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/l2_lru.sv
// Combinational true-LRU for one set: ages after touching a way, and the oldest way.
module l2_lru
    import l2_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int AW   = clog2(WAYS)
) (
    input  logic [WAYS-1:0][AW-1:0] i_age,
    input  logic [AW-1:0]           i_touch,
    output logic [WAYS-1:0][AW-1:0] o_age,
    output logic [AW-1:0]           o_victim
);

    logic [AW-1:0] w_old;

    always_comb begin
        w_old    = i_age[i_touch];
        o_victim = '0;
        o_age    = i_age;
        for (int i = 0; i < WAYS; i++) begin
            if (i_age[i] == AW'(WAYS - 1)) o_victim = AW'(i);
            // Ways younger than the touched one age by one; the touched way becomes newest.
            if (AW'(i) == i_touch)      o_age[i] = '0;
            else if (i_age[i] < w_old)  o_age[i] = i_age[i] + AW'(1);
        end
    end

endmodule

// File: rtl/l2_assoc.sv
// N-way set-associative write-back L2 with true-LRU replacement and dirty-victim reporting.
// Three-cycle request turnaround (IDLE -> LOOKUP -> RESP); responses are not back-pressured.
module l2_assoc
    import l2_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int INDEX_SIZE  = 4,
    parameter int OFFSET_SIZE = 2,
    parameter int WAYS        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 hit,
    output logic                 evict_valid,
    output logic [WORD_SIZE-1:0] evict_addr,
    output logic [WORD_SIZE-1:0] evict_data
);

    localparam int TAG_SIZE = WORD_SIZE - INDEX_SIZE - OFFSET_SIZE;
    localparam int SETS     = 2 ** INDEX_SIZE;
    localparam int AW       = clog2(WAYS);

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_SIZE-1:0]  tag;
        logic [WORD_SIZE-1:0] data;
    } line_t;

    state_t                  r_state;
    logic                    r_wr;
    logic [TAG_SIZE-1:0]     r_tag;
    logic [INDEX_SIZE-1:0]   r_index;
    logic [WORD_SIZE-1:0]    r_wdata;
    line_t                   r_lines [SETS][WAYS];
    logic [WAYS-1:0][AW-1:0] r_age   [SETS];

    line_t                   w_set [WAYS];
    logic                    w_hit;
    logic [AW-1:0]           w_hit_way;
    logic                    w_free;
    logic [AW-1:0]           w_free_way;
    logic [AW-1:0]           w_victim;
    logic [AW-1:0]           w_way;
    logic [WAYS-1:0][AW-1:0] w_next_age;
    logic                    w_evict;
    logic                    w_unused_ofs;

    assign w_unused_ofs = ^addr[OFFSET_SIZE-1:0];
    assign req_ready    = (r_state == IDLE) && rst_n;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_set[i] = r_lines[r_index][i];
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_set[i].valid) begin
                w_free     = 1'b1;
                w_free_way = AW'(i);
            end
            if (w_set[i].valid && (w_set[i].tag == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(i);
            end
        end
    end

    assign w_way   = w_hit ? w_hit_way : (w_free ? w_free_way : w_victim);
    assign w_evict = r_wr && !w_hit && w_set[w_way].valid && w_set[w_way].dirty;

    l2_lru #(
        .WAYS (WAYS),
        .AW   (AW)
    ) u_lru (
        .i_age    (r_age[r_index]),
        .i_touch  (w_way),
        .o_age    (w_next_age),
        .o_victim (w_victim)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            r_tag       <= '0;
            r_index     <= '0;
            r_wdata     <= '0;
            resp_valid  <= 1'b0;
            rdata       <= '0;
            hit         <= 1'b0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_data  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_lines[s][w] <= '0;
                    r_age[s][w]   <= AW'(w);
                end
            end
        end else begin
            resp_valid  <= 1'b0;
            evict_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_wr    <= wr_en;
                        r_tag   <= addr[WORD_SIZE-1 -: TAG_SIZE];
                        r_index <= addr[OFFSET_SIZE +: INDEX_SIZE];
                        r_wdata <= wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_state    <= RESP;
                    resp_valid <= 1'b1;
                    hit        <= w_hit;
                    if (r_wr) begin
                        rdata                   <= r_wdata;
                        r_lines[r_index][w_way] <= '{valid: 1'b1, dirty: 1'b1,
                                                     tag: r_tag, data: r_wdata};
                    end else begin
                        rdata <= w_hit ? w_set[w_hit_way].data : '0;
                    end
                    if (w_evict) begin
                        evict_valid <= 1'b1;
                        evict_addr  <= {w_set[w_way].tag, r_index, {OFFSET_SIZE{1'b0}}};
                        evict_data  <= w_set[w_way].data;
                    end
                    // Read misses leave replacement order untouched.
                    if (w_hit || r_wr) r_age[r_index] <= w_next_age;
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
